// File: rtl/execute_stage_if.sv
// Execute-stage bus: the E pipeline register fields, the M/W status used to
// suppress CC updates, and the execute results handed to the M register.
// The slave side is the execute stage; the master side is whatever drives E.
interface execute_stage_if;
    logic [2:0]  stat_e;
    logic [3:0]  icode_e;
    logic [3:0]  ifun_e;
    logic [3:0]  rA_e;
    logic [3:0]  rB_e;
    logic [63:0] valc_e;
    logic [63:0] valA_e;
    logic [63:0] valB_e;
    logic [2:0]  stat_m;
    logic [2:0]  stat_w;

    logic [2:0]  stat_out;
    logic [63:0] valE;
    logic [63:0] valA_out;
    logic        cnd;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        zf;
    logic        sf;
    logic        of;

    modport master (
        output stat_e, icode_e, ifun_e, rA_e, rB_e, valc_e, valA_e, valB_e,
               stat_m, stat_w,
        input  stat_out, valE, valA_out, cnd, dstE, dstM, zf, sf, of
    );

    modport slave (
        input  stat_e, icode_e, ifun_e, rA_e, rB_e, valc_e, valA_e, valB_e,
               stat_m, stat_w,
        output stat_out, valE, valA_out, cnd, dstE, dstM, zf, sf, of
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 style execute stage: ALU, condition evaluation, destination
// selection and the condition-code register (the only state in the block).
// Optional feature: define EXEC_MULQ_EN to add mulq (OPq ifun 4).
module execute_stage (
    input  logic              clk,
    input  logic              rst_n,
    execute_stage_if.slave    ex
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3,
        ALU_MUL = 4'h4
    } alu_fn_e;

    logic        zf_q, sf_q, of_q;
    logic        zf_d, sf_d, of_d;

    logic [63:0] val_e;
    logic [63:0] op_result;
    logic        op_of;
    logic        op_supported;
    logic        cond;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [2:0]  stat_res;
    logic        cc_update;
    logic        m_bad;
    logic        w_bad;

`ifdef EXEC_MULQ_EN
    logic [127:0] mul_product;
    assign mul_product = {64'd0, ex.valB_e} * {64'd0, ex.valA_e};
`endif

    // OPq datapath: result and overflow for the selected function code
    always_comb begin
        op_result    = 64'd0;
        op_of        = 1'b0;
        op_supported = 1'b1;
        case (ex.ifun_e)
            ALU_ADD: begin
                op_result = ex.valB_e + ex.valA_e;
                op_of     = (ex.valA_e[63] == ex.valB_e[63]) &&
                            (op_result[63] != ex.valB_e[63]);
            end
            ALU_SUB: begin
                op_result = ex.valB_e - ex.valA_e;
                op_of     = (ex.valA_e[63] != ex.valB_e[63]) &&
                            (op_result[63] != ex.valB_e[63]);
            end
            ALU_AND: op_result = ex.valB_e & ex.valA_e;
            ALU_XOR: op_result = ex.valB_e ^ ex.valA_e;
`ifdef EXEC_MULQ_EN
            ALU_MUL: begin
                op_result = mul_product[63:0];
                op_of     = |mul_product[127:64];
            end
`endif
            default: begin
                op_result    = 64'd0;
                op_supported = 1'b0;
            end
        endcase
    end

    // valE selection by instruction class and the status forwarded to M
    always_comb begin
        val_e    = 64'd0;
        stat_res = ex.stat_e;
        case (ex.icode_e)
            I_RRMOVQ:          val_e = ex.valA_e;
            I_IRMOVQ:          val_e = ex.valc_e;
            I_RMMOVQ, I_MRMOVQ: val_e = ex.valB_e + ex.valc_e;
            I_OPQ: begin
                val_e = op_result;
                if (!op_supported) begin
                    stat_res = STAT_INS;
                end
            end
            I_CALL, I_PUSHQ:   val_e = ex.valB_e - 64'd8;
            I_RET, I_POPQ:     val_e = ex.valB_e + 64'd8;
            default:           val_e = 64'd0;
        endcase
    end

    // Branch / conditional-move condition from the registered flags
    always_comb begin
        cond = 1'b0;
        if (ex.icode_e == I_RRMOVQ || ex.icode_e == I_JXX) begin
            case (ex.ifun_e)
                4'h0:    cond = 1'b1;
                4'h1:    cond = (sf_q ^ of_q) | zf_q;
                4'h2:    cond = sf_q ^ of_q;
                4'h3:    cond = zf_q;
                4'h4:    cond = ~zf_q;
                4'h5:    cond = ~(sf_q ^ of_q);
                4'h6:    cond = ~(sf_q ^ of_q) & ~zf_q;
                default: cond = 1'b0;
            endcase
        end
    end

    // Register-file write destinations for valE and the memory read value
    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (ex.icode_e)
            I_IRMOVQ, I_OPQ:                 dst_e = ex.rB_e;
            I_RRMOVQ:                        dst_e = cond ? ex.rB_e : REG_NONE;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = REG_RSP;
            default:                         dst_e = REG_NONE;
        endcase
        if (ex.icode_e == I_MRMOVQ || ex.icode_e == I_POPQ) begin
            dst_m = ex.rA_e;
        end
    end

    // Next CC value: only a clean OPq with no exception further down the
    // pipe may change the flags, otherwise they hold
    always_comb begin
        m_bad     = (ex.stat_m == STAT_HLT) || (ex.stat_m == STAT_ADR) ||
                    (ex.stat_m == STAT_INS);
        w_bad     = (ex.stat_w == STAT_HLT) || (ex.stat_w == STAT_ADR) ||
                    (ex.stat_w == STAT_INS);
        cc_update = (ex.icode_e == I_OPQ) && (ex.stat_e == STAT_AOK) &&
                    op_supported && !m_bad && !w_bad;
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (cc_update) begin
            zf_d = (op_result == 64'd0);
            sf_d = op_result[63];
            of_d = op_of;
        end
    end

    // CC register; reset leaves the flags as after a zero result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign ex.stat_out = stat_res;
    assign ex.valE     = val_e;
    assign ex.valA_out = ex.valA_e;
    assign ex.cnd      = cond;
    assign ex.dstE     = dst_e;
    assign ex.dstM     = dst_m;
    assign ex.zf       = zf_q;
    assign ex.sf       = sf_q;
    assign ex.of       = of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage with hand-written sequences
// for asynchronous reset and reset/update collisions.
module tb_execute_stage;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;
    localparam logic [3:0] RN  = 4'hF;

    logic clk;
    logic rst_n;

    execute_stage_if ex_if ();

    execute_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (ex_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  stat_e;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [2:0]  stat_m;
        logic [2:0]  stat_w;
        logic [63:0] x_vale;
        logic        x_cnd;
        logic [3:0]  x_dste;
        logic [3:0]  x_dstm;
        logic [2:0]  x_stat;
        logic        x_zf;
        logic        x_sf;
        logic        x_of;
    } vec_t;

    vec_t vecs[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ex_if.stat_e  = v.stat_e;
        ex_if.icode_e = v.icode;
        ex_if.ifun_e  = v.ifun;
        ex_if.rA_e    = v.ra;
        ex_if.rB_e    = v.rb;
        ex_if.valc_e  = v.valc;
        ex_if.valA_e  = v.vala;
        ex_if.valB_e  = v.valb;
        ex_if.stat_m  = v.stat_m;
        ex_if.stat_w  = v.stat_w;
    endtask

    task automatic checkCc(input string name, input logic z, input logic s,
                           input logic o);
        checkOutput({name, ".zf"}, {63'd0, ex_if.zf}, {63'd0, z});
        checkOutput({name, ".sf"}, {63'd0, ex_if.sf}, {63'd0, s});
        checkOutput({name, ".of"}, {63'd0, ex_if.of}, {63'd0, o});
    endtask

    vec_t idle;

    initial begin
        // name, stat_e, icode, ifun, rA, rB, valC, valA, valB, stat_m, stat_w,
        // valE, cnd, dstE, dstM, stat_out, zf/sf/of after the edge
        vecs.push_back('{"cmove", AOK, 4'h2, 4'h3, 4'h1, 4'h2, 64'd0, 64'h1234, 64'd0, AOK, AOK,
                         64'h1234, 1'b1, 4'h2, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"cmovne", AOK, 4'h2, 4'h4, 4'h1, 4'h2, 64'd0, 64'h55, 64'd0, AOK, AOK,
                         64'h55, 1'b0, RN, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"irmovq", AOK, 4'h3, 4'h0, RN, 4'h5, 64'hABCD, 64'd0, 64'd0, AOK, AOK,
                         64'hABCD, 1'b0, 4'h5, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"rmmovq", AOK, 4'h4, 4'h0, 4'h1, 4'h3, 64'h10, 64'd0, 64'h20, AOK, AOK,
                         64'h30, 1'b0, RN, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"mrmovq", AOK, 4'h5, 4'h0, 4'h6, 4'h3, 64'h8, 64'd0, 64'h100, AOK, AOK,
                         64'h108, 1'b0, RN, 4'h6, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"addq_ovf", AOK, 4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, AOK, AOK,
                         64'h8000_0000_0000_0000, 1'b0, 4'h2, RN, AOK, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"jge", AOK, 4'h7, 4'h5, RN, RN, 64'h40, 64'd0, 64'd0, AOK, AOK,
                         64'd0, 1'b1, RN, RN, AOK, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"jg", AOK, 4'h7, 4'h6, RN, RN, 64'h40, 64'd0, 64'd0, AOK, AOK,
                         64'd0, 1'b1, RN, RN, AOK, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"subq_madr", AOK, 4'h6, 4'h1, 4'h1, 4'h2, 64'd0, 64'd5, 64'd5, ADR, AOK,
                         64'd0, 1'b0, 4'h2, RN, AOK, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"subq_eq", AOK, 4'h6, 4'h1, 4'h1, 4'h2, 64'd0, 64'd5, 64'd5, AOK, AOK,
                         64'd0, 1'b0, 4'h2, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"jle", AOK, 4'h7, 4'h1, RN, RN, 64'h40, 64'd0, 64'd0, AOK, AOK,
                         64'd0, 1'b1, RN, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"pushq", AOK, 4'hA, 4'h0, 4'h3, RN, 64'd0, 64'h77, 64'h100, AOK, AOK,
                         64'hF8, 1'b0, 4'h4, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"popq", AOK, 4'hB, 4'h0, 4'h3, RN, 64'd0, 64'h100, 64'h100, AOK, AOK,
                         64'h108, 1'b0, 4'h4, 4'h3, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ret", AOK, 4'h9, 4'h0, RN, RN, 64'd0, 64'h200, 64'h200, AOK, AOK,
                         64'h208, 1'b0, 4'h4, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"subq_neg", AOK, 4'h6, 4'h1, 4'h1, 4'h2, 64'd0, 64'd1, 64'd0, AOK, AOK,
                         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h2, RN, AOK, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"jl", AOK, 4'h7, 4'h2, RN, RN, 64'h40, 64'd0, 64'd0, AOK, AOK,
                         64'd0, 1'b1, RN, RN, AOK, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"subq_ovf", AOK, 4'h6, 4'h1, 4'h1, 4'h2, 64'd0, 64'd1, 64'h8000_0000_0000_0000, AOK, AOK,
                         64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'h2, RN, AOK, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"cmovl", AOK, 4'h2, 4'h2, 4'h1, 4'h7, 64'd0, 64'd9, 64'd0, AOK, AOK,
                         64'd9, 1'b1, 4'h7, RN, AOK, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"andq", AOK, 4'h6, 4'h2, 4'h1, 4'h3, 64'd0, 64'hF0F0, 64'h0FF0, AOK, AOK,
                         64'h00F0, 1'b0, 4'h3, RN, AOK, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"xorq", AOK, 4'h6, 4'h3, 4'h1, 4'h3, 64'd0, 64'hFF, 64'hFF, AOK, AOK,
                         64'd0, 1'b0, 4'h3, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"addq_ehlt", HLT, 4'h6, 4'h0, 4'h1, 4'h3, 64'd0, 64'd1, 64'd1, AOK, AOK,
                         64'd2, 1'b0, 4'h3, RN, HLT, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"addq_wins", AOK, 4'h6, 4'h0, 4'h1, 4'h3, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, AOK, INS,
                         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h3, RN, AOK, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"addq_pos", AOK, 4'h6, 4'h0, 4'h1, 4'h3, 64'd0, 64'd1, 64'd2, AOK, AOK,
                         64'd3, 1'b0, 4'h3, RN, AOK, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"opq_f5", AOK, 4'h6, 4'h5, 4'h1, 4'h3, 64'd0, 64'd7, 64'd7, AOK, AOK,
                         64'd0, 1'b0, 4'h3, RN, INS, 1'b0, 1'b0, 1'b0});
`ifdef EXEC_MULQ_EN
        vecs.push_back('{"mulq", AOK, 4'h6, 4'h4, 4'h1, 4'h3, 64'd0, 64'h1_0000_0000, 64'h1_0000_0000, AOK, AOK,
                         64'd0, 1'b0, 4'h3, RN, AOK, 1'b1, 1'b0, 1'b1});
`else
        vecs.push_back('{"opq_f4", AOK, 4'h6, 4'h4, 4'h1, 4'h3, 64'd0, 64'h1_0000_0000, 64'h1_0000_0000, AOK, AOK,
                         64'd0, 1'b0, 4'h3, RN, INS, 1'b0, 1'b0, 1'b0});
`endif
        vecs.push_back('{"cmov_f7", AOK, 4'h2, 4'h7, 4'h1, 4'h2, 64'd0, 64'h66, 64'd0, AOK, AOK,
                         64'h66, 1'b0, RN, RN, AOK, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"halt", HLT, 4'h0, 4'h0, RN, RN, 64'd0, 64'h3, 64'h3, AOK, AOK,
                         64'd0, 1'b0, RN, RN, HLT, 1'b0, 1'b0, 1'b0});

        idle = '{"nop", AOK, 4'h1, 4'h0, RN, RN, 64'd0, 64'd0, 64'd0, AOK, AOK,
                 64'd0, 1'b0, RN, RN, AOK, 1'b0, 1'b0, 1'b0};

        // Reset phase: flags forced while rst_n is low
        rst_n = 1'b0;
        applyStimulus(idle);
        @(negedge clk);
        @(negedge clk);
        checkCc("reset", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Table: combinational results mid-cycle, then flags after the edge
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".valE"}, ex_if.valE, vecs[i].x_vale);
            checkOutput({vecs[i].name, ".cnd"}, {63'd0, ex_if.cnd}, {63'd0, vecs[i].x_cnd});
            checkOutput({vecs[i].name, ".dstE"}, {60'd0, ex_if.dstE}, {60'd0, vecs[i].x_dste});
            checkOutput({vecs[i].name, ".dstM"}, {60'd0, ex_if.dstM}, {60'd0, vecs[i].x_dstm});
            checkOutput({vecs[i].name, ".stat"}, {61'd0, ex_if.stat_out}, {61'd0, vecs[i].x_stat});
            checkOutput({vecs[i].name, ".valA_out"}, ex_if.valA_out, vecs[i].vala);
            @(posedge clk);
            #1;
            checkCc(vecs[i].name, vecs[i].x_zf, vecs[i].x_sf, vecs[i].x_of);
        end

        // Asynchronous reset between edges: set zf=0 first, then pull rst_n
        @(negedge clk);
        applyStimulus('{"add_nz", AOK, 4'h6, 4'h0, 4'h1, 4'h3, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, AOK, AOK,
                        64'd0, 1'b0, RN, RN, AOK, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        checkCc("pre_async", 1'b0, 1'b1, 1'b0);
        applyStimulus(idle);
        #2;
        rst_n = 1'b0;
        #1;
        checkCc("async_rst", 1'b1, 1'b0, 1'b0);

        // Reset held across a qualifying update edge keeps reset values
        applyStimulus('{"add_col", AOK, 4'h6, 4'h0, 4'h1, 4'h3, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, AOK, AOK,
                        64'd0, 1'b0, RN, RN, AOK, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        checkCc("rst_vs_upd", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkCc("post_release", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkCc("first_update", 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        applyStimulus(idle);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
  clk  input  1  single clock; CC register updates on rising edge
  rst_n  input  1  asynchronous, active-low reset
  stat_e  input  3  status of the instruction in E (AOK=1, HLT=2, ADR=3, INS=4)
  icode_e  input  4  instruction code of the instruction in E
  ifun_e  input  4  function code of the instruction in E
  rA_e  input  4  register A specifier (F = none)
  rB_e  input  4  register B specifier (F = none)
  valc_e  input  64  constant word
  valA_e  input  64  operand A
  valB_e  input  64  operand B
  stat_m  input  3  status of the instruction in M, used for CC inhibit
  stat_w  input  3  status of the instruction in W, used for CC inhibit
  stat_out  output  3  status forwarded to the M register
  valE  output  64  ALU result
  valA_out  output  64  valA_e passed through unchanged
  cnd  output  1  condition result for cmovXX and jXX
  dstE  output  4  destination register for valE
  dstM  output  4  destination register for the memory read
  zf, sf, of  output  1 each  current condition-code register

Function
REQ-002 valE, cnd, dstE, dstM, stat_out and valA_out SHALL be combinational in the current-cycle inputs, with zero latency; the CC register is the only state.
REQ-003 valE SHALL be computed by icode as follows; all arithmetic is 64-bit two's complement, and carry-out is discarded:
  - 2: valA
  - 3: valC
  - 4/5: valB+valC
  - 6: valB OP valA
  - 8/A: valB-8
  - 9/B: valB+8
  - any other icode: 0
REQ-004 OPq ifun SHALL select the operation: 0=add, 1=sub (valB-valA), 2=and, 3=xor.
REQ-005 OPq with an unsupported ifun SHALL produce valE=0 and stat_out=INS, and SHALL leave CC unchanged.
REQ-006 stat_out SHALL equal stat_e in every case except REQ-005.
REQ-007 cnd SHALL be evaluated from the current CC by ifun:
  - 0: 1
  - 1: (sf^of)|zf
  - 2: sf^of
  - 3: zf
  - 4: !zf
  - 5: !(sf^of)
  - 6: !(sf^of)&!zf
  - ifun>6: 0
  - cnd SHALL be 0 when icode is not 2 or 7.
REQ-008 dstE SHALL be:
  - rB for icode 3 and 6
  - rB for icode 2 when cnd=1, else F
  - 4 (%rsp) for icode 8, 9, A and B
  - F otherwise.
REQ-009 dstM SHALL be rA for icode 5 and B, and F otherwise.
REQ-010 The CC register SHALL update on a rising clk edge only when all of the following hold:
  - icode_e=6
  - stat_e=AOK
  - the ifun is supported
  - stat_m is not in {HLT, ADR, INS}
  - stat_w is not in {HLT, ADR, INS}
REQ-011 On an update, the CC register SHALL take these values:
  - zf = (valE==0)
  - sf = valE[63]
  - of for add = (valA[63]==valB[63]) && (valE[63]!=valB[63])
  - of for sub = (valA[63]!=valB[63]) && (valE[63]!=valB[63])
  - of for and/xor = 0
REQ-012 When an OPq instruction that updates CC is followed by cmov/jXX, the dependent instruction SHALL see the new CC in the cycle after the OPq.

Reset
REQ-013 rst_n low SHALL immediately force zf=1, sf=0, of=0, independent of clk.
REQ-014 A reset asserted in the same cycle as a CC update SHALL win, leaving the reset values.
REQ-015 On rst_n deassertion, CC SHALL first update on the next qualifying rising edge.

Configuration
REQ-016 With EXEC_MULQ_EN defined, OPq ifun 4 SHALL compute valE = low 64 bits of valB*valA (unsigned).
REQ-017 With EXEC_MULQ_EN defined, mulq SHALL set zf and sf per REQ-011, and SHALL set of=1 when the high 64 bits of the product are nonzero.
REQ-018 With EXEC_MULQ_EN undefined, ifun 4 SHALL be unsupported and handled per REQ-005.

Verification
REQ-019 After reset release, rrmovq with ifun 3 (cmove) and rB=2 -> cnd=1, dstE=2.
REQ-020 addq with valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, then clock -> valE=0x8000_0000_0000_0000; after the edge zf=0, sf=1, of=1.
REQ-021 subq with valA=5, valB=5, stat_m=ADR, then clock -> valE=0 and CC remains at its prior value.
REQ-022 subq with valA=5, valB=5 and all stat AOK, then clock, then jle -> cnd=1.
REQ-023 pushq with valB=0x100 -> valE=0xF8, dstE=4. popq with valB=0x100 and rA=3 -> valE=0x108, dstE=4, dstM=3.
REQ-024 OPq with ifun=4 -> without EXEC_MULQ_EN: stat_out=INS, valE=0, CC unchanged. With EXEC_MULQ_EN, valA=2^32 and valB=2^32: valE=0, zf=1, of=1 after the clock edge.
